// File: rtl/fetch_stage.sv
// fetch_stage: MIPS IF stage. Owns the PC and the IF/ID register and drives a
// single-outstanding-request instruction-memory port.
// Optional feature macro: FETCH_PERF_CNT_EN adds stall/flush performance counters.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        PCWrite,
    input  logic        IF_ID_Write,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] IF_ID_PC4,
    output logic [31:0] IF_ID_Instr,
    output logic        IF_ID_Valid
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] fetch_stall_cnt,
    output logic [31:0] fetch_flush_cnt
`endif
);

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_HOLD  = 2'd2,
        S_DROP  = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_hold_buf;
    logic [XLEN-1:0] w_pc4;
    logic [XLEN-1:0] w_deliver_instr;
    logic            w_accept;
    logic            w_deliver;
    logic            w_capture;

    assign w_accept  = PCWrite & IF_ID_Write;
    assign w_pc4     = r_pc + XLEN'(4);
    assign imem_addr = r_pc;
    // A request goes out whenever we sit in FETCH and are not being redirected
    assign imem_req  = (r_state == S_FETCH) & ~redirect_valid;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and delivery decisions; redirect overrides everything
    always_comb begin
        w_state_nxt     = r_state;
        w_deliver       = 1'b0;
        w_capture       = 1'b0;
        w_deliver_instr = r_hold_buf;
        case (r_state)
            S_FETCH: begin
                if (imem_req) begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    if (w_accept) begin
                        w_deliver       = 1'b1;
                        w_deliver_instr = imem_rdata;
                        w_state_nxt     = S_FETCH;
                    end else begin
                        w_capture   = 1'b1;
                        w_state_nxt = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (w_accept) begin
                    w_deliver   = 1'b1;
                    w_state_nxt = S_FETCH;
                end
            end
            S_DROP: begin
                if (imem_rvalid) begin
                    w_state_nxt = S_FETCH;
                end
            end
            default: begin
                w_state_nxt = S_FETCH;
            end
        endcase
        if (redirect_valid) begin
            w_deliver = 1'b0;
            w_capture = 1'b0;
            // An outstanding request must still be drained unless it lands now
            if ((r_state == S_WAIT) || (r_state == S_DROP)) begin
                w_state_nxt = imem_rvalid ? S_FETCH : S_DROP;
            end else begin
                w_state_nxt = S_FETCH;
            end
        end
    end

    // PC, IF/ID register and hold buffer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc        <= RESET_PC;
            r_hold_buf  <= '0;
            IF_ID_PC4   <= '0;
            IF_ID_Instr <= NOP_INSTR;
            IF_ID_Valid <= 1'b0;
        end else begin
            if (w_capture) begin
                r_hold_buf <= imem_rdata;
            end
            if (redirect_valid) begin
                r_pc        <= redirect_pc;
                IF_ID_PC4   <= '0;
                IF_ID_Instr <= NOP_INSTR;
                IF_ID_Valid <= 1'b0;
            end else if (w_deliver) begin
                r_pc        <= w_pc4;
                IF_ID_PC4   <= w_pc4;
                IF_ID_Instr <= w_deliver_instr;
                IF_ID_Valid <= 1'b1;
            end else if (IF_ID_Write) begin
                IF_ID_PC4   <= '0;
                IF_ID_Instr <= NOP_INSTR;
                IF_ID_Valid <= 1'b0;
            end
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [XLEN-1:0] r_stall_cnt;
    logic [XLEN-1:0] r_flush_cnt;

    // Stall and flush cycle counters, free-running with wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (!w_accept) begin
                r_stall_cnt <= r_stall_cnt + XLEN'(1);
            end
            if (redirect_valid) begin
                r_flush_cnt <= r_flush_cnt + XLEN'(1);
            end
        end
    end

    assign fetch_stall_cnt = r_stall_cnt;
    assign fetch_flush_cnt = r_flush_cnt;
`endif

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the five-stage MIPS pipeline: owns the PC register and the IF/ID pipeline register, and drives a single-outstanding-request instruction-memory port. Consumes the hazard unit's `PCWrite`/`IF_ID_Write` stall controls and the EX-stage branch/jump redirect. Feeds `IF_ID_Instr`/`IF_ID_PC4` to decode and, through decode, the `IF_ID_RegisterRs/Rt` fields the hazard unit compares.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value after reset.
- `NOP_INSTR`, default 32'h0000_0000: instruction word loaded into IF/ID on bubble or flush (`sll $0,$0,0`).

- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `PCWrite` in 1: hazard unit; 0 = PC must not advance.
- `IF_ID_Write` in 1: hazard unit; 0 = IF/ID must hold.
- `redirect_valid` in 1: taken branch/jump this cycle.
- `redirect_pc` in 32: redirect target.
- `imem_req` out 1: request strobe, one cycle per request.
- `imem_addr` out 32: request address, equals PC.
- `imem_rvalid` in 1: response valid, ≥1 cycle after `imem_req`.
- `imem_rdata` in 32: instruction word, qualified by `imem_rvalid`.
- `IF_ID_PC4` out 32: PC+4 of the instruction in IF/ID.
- `IF_ID_Instr` out 32: instruction in IF/ID.
- `IF_ID_Valid` out 1: IF/ID holds a real instruction.
- `fetch_stall_cnt` out 32: present only with `FETCH_PERF_CNT_EN`.
- `fetch_flush_cnt` out 32: present only with `FETCH_PERF_CNT_EN`.

## Operation
- `accept = PCWrite & IF_ID_Write`.
- **FETCH**:
  - `imem_req = ~redirect_valid`, `imem_addr = pc`.
  - If `imem_req` is asserted, go to WAIT.
- **WAIT**:
  - On `imem_rvalid & accept`: IF/ID ← {pc+4, rdata, valid=1}; pc ← pc+4; go to FETCH.
  - On `imem_rvalid & ~accept`: capture rdata in the hold buffer; go to HOLD.
- **HOLD**:
  - On `accept`: IF/ID ← {pc+4, buffer, 1}; pc ← pc+4; go to FETCH.
- **DROP**:
  - Waits for the stale response.
  - On `imem_rvalid`: discard the data; go to FETCH.
- **Redirect** (highest priority, any state):
  - pc ← `redirect_pc`.
  - IF/ID ← {0, NOP_INSTR, 0}, regardless of `IF_ID_Write`.
  - FETCH → FETCH, because no request is issued that cycle.
  - WAIT without rvalid → DROP.
  - WAIT with rvalid in the same cycle → FETCH, response discarded.
  - HOLD → FETCH, buffer discarded.
  - DROP → DROP, pc updated.
- **Bubble**: in any cycle where `IF_ID_Write=1`, no instruction is delivered and there is no redirect, IF/ID ← {0, NOP_INSTR, 0}.
- **Stall**: `IF_ID_Write=0` holds IF/ID. `PCWrite=0` holds pc. Neither blocks an in-flight response; it is parked in HOLD.
- At most one outstanding request. `imem_rvalid` in FETCH or HOLD is a protocol violation and is ignored.
- pc+4 wraps modulo 2^32. `redirect_pc[1:0]` is passed through unchanged.

## Timing
- Reset values:
  - pc = `RESET_PC`; state = FETCH.
  - `IF_ID_Instr` = `NOP_INSTR`; `IF_ID_PC4` = 0; `IF_ID_Valid` = 0.
  - Counters = 0.
  - `imem_req` = 1 combinationally while in reset and FETCH; memory must ignore it while `rst_n=0`.
- Latency with a 1-cycle memory:
  - `imem_req` in cycle N, `imem_rvalid` in N+1.
  - IF/ID valid from N+2.
  - Next `imem_req` in N+2.
  - Peak throughput: one instruction per 2 cycles.
- HOLD release: IF/ID loads on the first edge where `accept=1`.
- Reset asserted mid-WAIT or mid-HOLD: immediate return to reset values. A response arriving after reset release, in FETCH, is ignored.
- All control inputs are sampled at the rising edge; no combinational path from `imem_rdata` to any output.

## Configuration
- `FETCH_PERF_CNT_EN` defined:
  - `fetch_stall_cnt` increments every cycle with `rst_n=1` and `accept=0`.
  - `fetch_flush_cnt` increments every cycle with `redirect_valid=1`.
  - Both are 32-bit, wrap at 2^32, and reset to 0.
- `FETCH_PERF_CNT_EN` undefined: both ports and both registers are absent; all other behaviour is identical.

## Test plan
- **Straight line**: reset release, 1-cycle memory returning 32'h2001_0005, 32'h2002_0007 → IF/ID valid at cycles 2 and 4 with PC4 = 4 and 8; `IF_ID_Valid`=0 in between.
- **Load-use stall**: `PCWrite`=`IF_ID_Write`=0 for 3 cycles while a response arrives → state HOLD; IF/ID unchanged for 3 cycles; on release, the buffered word is loaded with the correct PC4 and pc advances by 4.
- **Redirect in WAIT**: 3-cycle memory, `redirect_valid` with `redirect_pc`=32'h0000_0100 one cycle after the request → DROP; stale word never reaches IF/ID; next `imem_addr`=32'h100.
- **Redirect beats stall**: redirect with `IF_ID_Write`=0 and IF/ID valid → IF/ID becomes {0, NOP_INSTR, 0} at the next edge; pc=`redirect_pc`.
- **Reset mid-operation**: `rst_n` low during WAIT → pc=`RESET_PC`, `IF_ID_Valid`=0 immediately; a late `imem_rvalid` after release is ignored.
- **Counters** (macro defined): 5 stall cycles plus 2 redirects → `fetch_stall_cnt`=5, `fetch_flush_cnt`=2; wrap check from 32'hFFFF_FFFF to 0.
